pattern_detection_multi: RTL and testbench

- Parametrised multi-slot successor to the single-pattern detector in the DSP slice output stage.
- Compares the post-adder result against NUM_PAT independently configured pattern/mask slots and produces per-slot detect, bdetect, past, overflow and underflow flags.
- Adds a priority match index and per-slot saturating hit counters.
- All static settings load through one serial configuration chain.

---
 rtl/pattern_detect_pkg.sv | 48 ++++
 rtl/pattern_slot.sv | 124 ++++++++++++
 rtl/pattern_detection_multi.sv | 113 +++++++++++
 tb/tb_pattern_detection_multi.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_detect_pkg
// Purpose  : Shared definitions for the multi-slot pattern detector.
//            Configuration chain length and field-offset helpers, plus the
//            SEL_MASK encodings.
// Revision : 1.0  initial release
// ============================================================================
package pattern_detect_pkg;

  // SEL_MASK encodings
  localparam logic [1:0] MASK_CFG  = 2'b00;  // static MASK field
  localparam logic [1:0] MASK_C    = 2'b01;  // C_reg used directly as mask
  localparam logic [1:0] MASK_RND1 = 2'b10;  // {~C_reg[W-2:0], 1'b0}
  localparam logic [1:0] MASK_RND2 = 2'b11;  // {~C_reg[W-3:0], 2'b00}

  // Global PREG bit sits at the very bottom of the chain; slots start above it.
  localparam int PREG_POS  = 0;
  localparam int SLOT_BASE = 1;
  localparam int MASK_OFF  = 0;

  // One slot: MASK (W) + SEL_MASK (2) + SEL_PATTERN (1) + PATTERN (W)
  function automatic int slot_len(input int width);
    return 2 * width + 3;
  endfunction

  function automatic int cfg_len(input int width, input int num_pat);
    return num_pat * slot_len(width) + 1;
  endfunction

  function automatic int slot_base(input int width, input int idx);
    return SLOT_BASE + idx * slot_len(width);
  endfunction

  function automatic int sel_mask_off(input int width);
    return width;
  endfunction

  function automatic int sel_pat_off(input int width);
    return width + 2;
  endfunction

  function automatic int pattern_off(input int width);
    return width + 3;
  endfunction

endpackage : pattern_detect_pkg
`default_nettype wire

// File: rtl/pattern_slot.sv
`default_nettype none
// ============================================================================
// Module   : pattern_slot
// Purpose  : One pattern/mask slot: pattern and mask selection, raw compare,
//            optional detect pipeline register, PAST registers, over/underflow
//            flags and a saturating hit counter.
// Ports    : clk, rst_n          clock, async active-low reset
//            c_reg, inter_p      dynamic pattern/mask source, value under test
//            rstp, cep, cnt_clr  detect clear, detect/counter enable, counter clear
//            cfg_shift           config chain is shifting (freezes loads)
//            preg                1: registered flags, 0: combinational flags
//            pattern, mask, sel_mask, sel_pattern   static slot configuration
//            detect, bdetect, detect_past, bdetect_past, overflow, underflow
//            hit_count           saturating match counter
// Revision : 1.0  initial release
// ============================================================================
module pattern_slot
  import pattern_detect_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] c_reg,
  input  logic [WIDTH-1:0] inter_p,
  input  logic             rstp,
  input  logic             cep,
  input  logic             cnt_clr,
  input  logic             cfg_shift,
  input  logic             preg,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] mask,
  input  logic [1:0]       sel_mask,
  input  logic             sel_pattern,
  output logic             detect,
  output logic             bdetect,
  output logic             detect_past,
  output logic             bdetect_past,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] hit_count
);

  logic [WIDTH-1:0] pat_sel;
  logic [WIDTH-1:0] mask_sel;
  logic [WIDTH-1:0] diff;
  logic             det_raw;
  logic             bdet_raw;
  logic             load_en;

  logic             det_d,   det_q;
  logic             bdet_d,  bdet_q;
  logic             past_d,  past_q;
  logic             bpast_d, bpast_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;

  always_comb begin
    pat_sel = sel_pattern ? c_reg : pattern;
    case (sel_mask)
      MASK_CFG:  mask_sel = mask;
      MASK_C:    mask_sel = c_reg;
      MASK_RND1: mask_sel = {~c_reg[WIDTH-2:0], 1'b0};
      default:   mask_sel = {~c_reg[WIDTH-3:0], 2'b00};
    endcase
  end

  // Masked bits are forced to 1 so they never block a match in either sense.
  assign diff     = inter_p ^ pat_sel;
  assign det_raw  = &(~diff | mask_sel);
  assign bdet_raw = &(diff | mask_sel);

  // A shifting config chain means the slot settings are in flux; freeze loads.
  assign load_en = cep & ~cfg_shift;

  assign detect  = preg ? det_q  : det_raw;
  assign bdetect = preg ? bdet_q : bdet_raw;

  always_comb begin
    det_d   = det_q;
    bdet_d  = bdet_q;
    if (rstp) begin
      det_d  = 1'b0;
      bdet_d = 1'b0;
    end else if (load_en) begin
      det_d  = det_raw;
      bdet_d = bdet_raw;
    end
    // PAST tracks the selected outputs every cycle regardless of enables.
    past_d  = detect;
    bpast_d = bdetect;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (load_en && detect && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q   <= 1'b0;
      bdet_q  <= 1'b0;
      past_q  <= 1'b0;
      bpast_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      det_q   <= det_d;
      bdet_q  <= bdet_d;
      past_q  <= past_d;
      bpast_q <= bpast_d;
      cnt_q   <= cnt_d;
    end
  end

  assign detect_past  = past_q;
  assign bdetect_past = bpast_q;
  assign overflow     = past_q  & ~detect & ~bdetect;
  assign underflow    = bpast_q & ~detect & ~bdetect;
  assign hit_count    = cnt_q;

endmodule : pattern_slot
`default_nettype wire

// File: rtl/pattern_detection_multi.sv
`default_nettype none
// ============================================================================
// Module   : pattern_detection_multi
// Purpose  : Multi-slot pattern detector for the DSP output stage. Holds the
//            serial configuration chain, the global PREG select and the
//            priority encoder over NUM_PAT pattern_slot instances.
// Ports    : clk, rst_n                 clock, async active-low reset
//            C_reg, inter_P             dynamic pattern/mask source, value under test
//            RSTP, CEP, cnt_clr         detect clear, enable, counter clear
//            configuration_input/enable/output   serial config chain
//            PATTERNDETECT, PATTERNBDETECT, *PAST, Overflow, Underflow  per slot
//            any_detect, match_idx      lowest-index match summary
//            hit_count                  slot i at [i*CNT_W +: CNT_W]
// Revision : 1.0  initial release
// ============================================================================
module pattern_detection_multi
  import pattern_detect_pkg::*;
#(
  parameter int WIDTH   = 48,
  parameter int NUM_PAT = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         C_reg,
  input  logic [WIDTH-1:0]         inter_P,
  input  logic                     RSTP,
  input  logic                     CEP,
  input  logic                     cnt_clr,
  input  logic                     configuration_input,
  input  logic                     configuration_enable,
  output logic                     configuration_output,
  output logic [NUM_PAT-1:0]       PATTERNDETECT,
  output logic [NUM_PAT-1:0]       PATTERNBDETECT,
  output logic [NUM_PAT-1:0]       PATTERNDETECTPAST,
  output logic [NUM_PAT-1:0]       PATTERNBDETECTPAST,
  output logic [NUM_PAT-1:0]       Overflow,
  output logic [NUM_PAT-1:0]       Underflow,
  output logic                     any_detect,
  output logic [IDX_W-1:0]         match_idx,
  output logic [NUM_PAT*CNT_W-1:0] hit_count
);

  localparam int CFG_LEN = cfg_len(WIDTH, NUM_PAT);

  logic [CFG_LEN-1:0] cfg_d, cfg_q;
  logic               preg;

  // Bit 0 takes the new bit, so the first bit in ends at the top of the chain.
  always_comb begin
    cfg_d = cfg_q;
    if (configuration_enable) begin
      cfg_d = {cfg_q[CFG_LEN-2:0], configuration_input};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else begin
      cfg_q <= cfg_d;
    end
  end

  assign configuration_output = cfg_q[CFG_LEN-1];
  assign preg                 = cfg_q[PREG_POS];

  generate
    for (genvar i = 0; i < NUM_PAT; i++) begin : g_slot
      localparam int BASE = slot_base(WIDTH, i);

      pattern_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk          (clk),
        .rst_n        (rst_n),
        .c_reg        (C_reg),
        .inter_p      (inter_P),
        .rstp         (RSTP),
        .cep          (CEP),
        .cnt_clr      (cnt_clr),
        .cfg_shift    (configuration_enable),
        .preg         (preg),
        .pattern      (cfg_q[BASE + pattern_off(WIDTH) +: WIDTH]),
        .mask         (cfg_q[BASE + MASK_OFF +: WIDTH]),
        .sel_mask     (cfg_q[BASE + sel_mask_off(WIDTH) +: 2]),
        .sel_pattern  (cfg_q[BASE + sel_pat_off(WIDTH)]),
        .detect       (PATTERNDETECT[i]),
        .bdetect      (PATTERNBDETECT[i]),
        .detect_past  (PATTERNDETECTPAST[i]),
        .bdetect_past (PATTERNBDETECTPAST[i]),
        .overflow     (Overflow[i]),
        .underflow    (Underflow[i]),
        .hit_count    (hit_count[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    match_idx = '0;
    for (int i = NUM_PAT - 1; i >= 0; i--) begin
      if (PATTERNDETECT[i]) begin
        match_idx = IDX_W'(i);
      end
    end
    any_detect = |PATTERNDETECT;
  end

endmodule : pattern_detection_multi
`default_nettype wire

// File: tb/tb_pattern_detection_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pattern_detection_multi
// Purpose  : Self-checking bench for pattern_detection_multi (WIDTH=8,
//            NUM_PAT=2, CNT_W=4) with a second instance daisy-chained on the
//            configuration port.
// Revision : 1.0  initial release
// ============================================================================
module tb_pattern_detection_multi;

  localparam int W  = 8;
  localparam int NP = 2;
  localparam int CW = 4;
  localparam int IW = 1;
  localparam int CL = 39;  // 2 * (2*8 + 3) + 1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  c_reg, inter_p;
  logic          rstp, cep, cnt_clr, cfg_in, cfg_en;

  logic          cfg_out1, any1;
  logic [NP-1:0] det1, bdet1, pdet1, pbdet1, ovf1, unf1;
  logic [IW-1:0] idx1;
  logic [NP*CW-1:0] cnt1;

  logic          cfg_out2, any2;
  logic [NP-1:0] det2, bdet2, pdet2, pbdet2, ovf2, unf2;
  logic [IW-1:0] idx2;
  logic [NP*CW-1:0] cnt2;

  pattern_detection_multi #(.WIDTH(W), .NUM_PAT(NP), .CNT_W(CW), .IDX_W(IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .C_reg(c_reg), .inter_P(inter_p), .RSTP(rstp), .CEP(cep),
    .cnt_clr(cnt_clr), .configuration_input(cfg_in), .configuration_enable(cfg_en),
    .configuration_output(cfg_out1), .PATTERNDETECT(det1), .PATTERNBDETECT(bdet1),
    .PATTERNDETECTPAST(pdet1), .PATTERNBDETECTPAST(pbdet1), .Overflow(ovf1),
    .Underflow(unf1), .any_detect(any1), .match_idx(idx1), .hit_count(cnt1)
  );

  pattern_detection_multi #(.WIDTH(W), .NUM_PAT(NP), .CNT_W(CW), .IDX_W(IW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .C_reg(c_reg), .inter_P(inter_p), .RSTP(rstp), .CEP(cep),
    .cnt_clr(cnt_clr), .configuration_input(cfg_out1), .configuration_enable(cfg_en),
    .configuration_output(cfg_out2), .PATTERNDETECT(det2), .PATTERNBDETECT(bdet2),
    .PATTERNDETECTPAST(pdet2), .PATTERNBDETECTPAST(pbdet2), .Overflow(ovf2),
    .Underflow(unf2), .any_detect(any2), .match_idx(idx2), .hit_count(cnt2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output records, pushed when stimulus is applied.
  typedef struct {
    string      tag;
    logic [1:0] det;
    logic [1:0] bdet;
  } exp_t;
  exp_t sb[$];

  task automatic sb_push(input string tag, input logic [1:0] det, input logic [1:0] bdet);
    exp_t e;
    e.tag  = tag;
    e.det  = det;
    e.bdet = bdet;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    logic [IW-1:0] eidx;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    eidx = e.det[0] ? 1'b0 : (e.det[1] ? 1'b1 : 1'b0);
    check({e.tag, ".det"},  det1,  e.det);
    check({e.tag, ".bdet"}, bdet1, e.bdet);
    check({e.tag, ".any"},  any1,  e.det != 2'b00);
    check({e.tag, ".idx"},  idx1,  eidx);
  endtask

  // Combinational vector table (PREG=0), one clock between vectors.
  typedef struct {
    logic [7:0] ip;
    logic [7:0] c;
    logic [1:0] det;
    logic [1:0] bdet;
  } vec_t;
  vec_t tbl[$];

  task automatic add_vec(input logic [7:0] ip, input logic [7:0] c,
                         input logic [1:0] det, input logic [1:0] bdet);
    vec_t v;
    v.ip = ip; v.c = c; v.det = det; v.bdet = bdet;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[k]) begin
      inter_p = tbl[k].ip;
      c_reg   = tbl[k].c;
      sb_push($sformatf("%s[%0d]", tag, k), tbl[k].det, tbl[k].bdet);
      #1;
      sb_check();
      step();
    end
    tbl.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CL-1:0] mk_cfg(
      input logic preg,
      input logic [7:0] p0, input logic [7:0] m0, input logic [1:0] sm0, input logic sp0,
      input logic [7:0] p1, input logic [7:0] m1, input logic [1:0] sm1, input logic sp1);
    logic [CL-1:0] v;
    v        = '0;
    v[0]     = preg;
    v[8:1]   = m0;
    v[10:9]  = sm0;
    v[11]    = sp0;
    v[19:12] = p0;
    v[27:20] = m1;
    v[29:28] = sm1;
    v[30]    = sp1;
    v[38:31] = p1;
    return v;
  endfunction

  // MSB goes in first so the register ends up equal to v.
  task automatic shift_cfg(input logic [CL-1:0] v);
    cfg_en = 1'b1;
    for (int i = CL - 1; i >= 0; i--) begin
      cfg_in = v[i];
      step();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [CL-1:0] cfg_a, cfg_b, cfg_c, cfg_d;

  initial begin
    rst_n = 1'b0; c_reg = '0; inter_p = 8'h33;
    rstp = 1'b0; cep = 1'b0; cnt_clr = 1'b0; cfg_in = 1'b0; cfg_en = 1'b0;
    cfg_a = mk_cfg(1'b0, 8'h5A, 8'h0F, 2'b00, 1'b0, 8'h00, 8'hFF, 2'b00, 1'b0);
    cfg_b = mk_cfg(1'b1, 8'h5A, 8'h0F, 2'b00, 1'b0, 8'h00, 8'hFF, 2'b00, 1'b0);
    cfg_c = mk_cfg(1'b0, 8'h00, 8'h00, 2'b10, 1'b1, 8'h00, 8'h00, 2'b11, 1'b1);
    cfg_d = mk_cfg(1'b0, 8'h3C, 8'h00, 2'b00, 1'b0, 8'hC3, 8'h00, 2'b00, 1'b0);

    // Reset state: all-zero config means pattern 0, mask 0, PREG=0.
    #12;
    check("rst.det",     det1,     2'b00);
    check("rst.bdet",    bdet1,    2'b00);
    check("rst.pdet",    pdet1,    2'b00);
    check("rst.ovf",     ovf1,     2'b00);
    check("rst.cnt",     cnt1,     8'h00);
    check("rst.cfg_out", cfg_out1, 1'b0);
    inter_p = 8'h00;
    #1;
    check("rst.det_zero_in", det1, 2'b11);
    inter_p = 8'h33;
    rst_n = 1'b1;
    step();

    // Config A, combinational flags.
    shift_cfg(cfg_a);
    check("cfgA.cfg_out", cfg_out1, 1'b0);
    add_vec(8'h5F, 8'h00, 2'b11, 2'b10);
    add_vec(8'hA0, 8'h00, 2'b10, 2'b11);
    add_vec(8'h50, 8'h00, 2'b11, 2'b10);
    add_vec(8'h33, 8'h00, 2'b10, 2'b10);
    add_vec(8'hAF, 8'h00, 2'b10, 2'b11);
    run_table("cfgA");

    // PREG=1: one-cycle latency, CEP hold, RSTP priority.
    do_reset();
    shift_cfg(cfg_b);
    inter_p = 8'h5A;
    sb_push("preg.before", 2'b00, 2'b00); #1; sb_check();
    cep = 1'b1;
    step();
    inter_p = 8'h33;
    sb_push("preg.lat1", 2'b11, 2'b10); #1; sb_check();
    step();
    sb_push("preg.next", 2'b10, 2'b10); sb_check();
    check("preg.past", pdet1, 2'b11);
    check("preg.ovf",  ovf1,  2'b01);
    check("preg.unf",  unf1,  2'b00);
    cep = 1'b0; inter_p = 8'h5A;
    step();
    sb_push("preg.hold", 2'b10, 2'b10); sb_check();
    cep = 1'b1; rstp = 1'b1;
    step();
    sb_push("preg.rstp", 2'b00, 2'b00); sb_check();
    rstp = 1'b0; cep = 1'b0;

    // Rounding masks: slot0 0xE0 (mode 10), slot1 0xC0 (mode 11), pattern = C_reg.
    do_reset();
    shift_cfg(cfg_c);
    add_vec(8'h0F, 8'h0F, 2'b11, 2'b00);
    add_vec(8'h2F, 8'h0F, 2'b01, 2'b00);
    add_vec(8'h1F, 8'h0F, 2'b00, 2'b00);
    add_vec(8'h10, 8'h0F, 2'b00, 2'b01);
    add_vec(8'h70, 8'h0F, 2'b00, 2'b11);
    run_table("rnd");
    inter_p = 8'h0F;
    step();
    inter_p = 8'h1F; #1;
    check("rnd.ovf_set", ovf1, 2'b11);
    step();
    check("rnd.ovf_clr", ovf1, 2'b00);
    inter_p = 8'h10;
    step();
    inter_p = 8'h1F; #1;
    check("rnd.unf_set", unf1, 2'b01);

    // Saturating counters.
    do_reset();
    shift_cfg(cfg_a);
    inter_p = 8'h5A;
    check("cnt.start", cnt1, 8'h00);
    cep = 1'b1;
    repeat (10) step();
    check("cnt.ten", cnt1, 8'hAA);
    repeat (10) step();
    check("cnt.sat", cnt1, 8'hFF);
    cnt_clr = 1'b1;
    step();
    check("cnt.clr", cnt1, 8'h00);
    cnt_clr = 1'b0;
    step();
    check("cnt.one", cnt1, 8'h11);
    inter_p = 8'h33;
    step();
    check("cnt.slot1_only", cnt1, 8'h21);

    // Asynchronous reset in the middle of a shift with live counters.
    cfg_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cfg_in = i[0];
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.det",     det1,     2'b00);
    check("arst.bdet",    bdet1,    2'b00);
    check("arst.pdet",    pdet1,    2'b00);
    check("arst.pbdet",   pbdet1,   2'b00);
    check("arst.ovf",     ovf1,     2'b00);
    check("arst.unf",     unf1,     2'b00);
    check("arst.any",     any1,     1'b0);
    check("arst.idx",     idx1,     1'b0);
    check("arst.cnt",     cnt1,     8'h00);
    check("arst.cfg_out", cfg_out1, 1'b0);
    cfg_en = 1'b0; cfg_in = 1'b0; cep = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    shift_cfg(cfg_a);
    add_vec(8'h5F, 8'h00, 2'b11, 2'b10);
    run_table("arst.reload");

    // Daisy chain: first CL bits end up in the downstream instance.
    do_reset();
    shift_cfg(cfg_d);
    shift_cfg(cfg_a);
    inter_p = 8'h3C; #1;
    check("daisy.det2_3c",  det2,  2'b01);
    check("daisy.bdet2_3c", bdet2, 2'b10);
    check("daisy.idx2_3c",  idx2,  1'b0);
    check("daisy.det1_3c",  det1,  2'b10);
    inter_p = 8'hC3; #1;
    check("daisy.det2_c3",  det2,  2'b10);
    check("daisy.bdet2_c3", bdet2, 2'b01);
    check("daisy.idx2_c3",  idx2,  1'b1);
    check("daisy.any2_c3",  any2,  1'b1);

    if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pattern_detection_multi
`default_nettype wire
